blink_arbiter: RTL and testbench

//  Shares the single board LED among 4 requesters. Each requester asks for N blinks.
//  The block grants requests round-robin, generates the blink timing from CLK50

---
 rtl/blink_arbiter.sv | 169 ++++++++++++++++
 tb/tb_blink_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/blink_arbiter.sv
// blink_arbiter
//   Shares one board LED among four status requesters. Requests are granted
//   round-robin; the owner gets CNT blinks (0 means 16) timed by an internal
//   prescaler. A forced dark gap follows before the next owner.
//
// Ports
//   CLK50  in   1   sole clock
//   RST    in   1   asynchronous, active-high reset
//   REQ    in   4   level request per requester
//   CNT    in   16  CNT[4i+3:4i] = blink count for requester i, 0 means 16
//   ACK    out  4   one-cycle pulse, request granted and count latched
//   DONE   out  4   one-cycle pulse, sequence plus gap finished
//   BUSY   out  1   high while not IDLE
//   OWNER  out  2   current / last granted requester
//   LED    out  1   LED drive, 1 = on
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | LED dark, prescaler held at 0, arbitrating pending requests
// ON    | LED lit for one half-period
// OFF   | LED dark between blinks, decides next blink or gap
// GAP   | forced dark for GAP_HALVES half-periods before release

module blink_arbiter #(
    parameter int TICK_DIV   = 12_500_000,
    parameter int GAP_HALVES = 4
) (
    input  logic        CLK50,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [15:0] CNT,
    output logic [3:0]  ACK,
    output logic [3:0]  DONE,
    output logic        BUSY,
    output logic [1:0]  OWNER,
    output logic        LED
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GAP_HALVES + 1);

    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HALVES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic [PW-1:0] presc_q,     presc_d;
    logic [4:0]    remaining_q, remaining_d;
    logic [GW-1:0] gap_q,       gap_d;
    logic [1:0]    ptr_q,       ptr_d;
    logic [1:0]    owner_q,     owner_d;
    logic [3:0]    ack_q,       ack_d;
    logic [3:0]    done_q,      done_d;
    logic          busy_q,      busy_d;
    logic          led_q,       led_d;

    logic          tick;
    logic          found;
    logic [1:0]    win;
    logic [1:0]    cand;
    logic [3:0]    cnt_w;

    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        cand  = 2'd0;
        // Search starts just after the last owner; i=4 wraps back to the
        // last owner itself so a lone requester can be granted again.
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        cnt_w = CNT[{win, 2'b00} +: 4];
    end

    always_comb begin
        tick        = (presc_q == TICK_MAX);
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        ack_d       = 4'b0000;
        done_d      = 4'b0000;

        // Held at 0 in IDLE so the first ON half-period after a grant is full length.
        if (state_q == S_IDLE || tick) presc_d = '0;
        else                           presc_d = presc_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_ON;
                    ack_d       = 4'b0001 << win;
                    owner_d     = win;
                    ptr_d       = win;
                    remaining_d = (cnt_w == 4'd0) ? 5'd16 : {1'b0, cnt_w};
                end
            end
            S_ON: begin
                if (tick) state_d = S_OFF;
            end
            S_OFF: begin
                if (tick) begin
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q > 5'd1) begin
                        state_d = S_ON;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_LAST;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (gap_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 4'b0001 << owner_q;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
        endcase

        led_d  = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            remaining_q <= 5'd0;
            gap_q       <= '0;
            ptr_q       <= 2'd3;
            owner_q     <= 2'd0;
            ack_q       <= 4'b0000;
            done_q      <= 4'b0000;
            busy_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            led_q       <= led_d;
        end
    end

    assign ACK   = ack_q;
    assign DONE  = done_q;
    assign BUSY  = busy_q;
    assign OWNER = owner_q;
    assign LED   = led_q;

endmodule

// File: tb/tb_blink_arbiter.sv
module tb_blink_arbiter;

    localparam int TD = 4;
    localparam int GH = 2;

    logic        CLK50 = 1'b0;
    logic        RST   = 1'b0;
    logic [3:0]  REQ   = 4'b0000;
    logic [15:0] CNT   = 16'h0000;
    logic [3:0]  ACK;
    logic [3:0]  DONE;
    logic        BUSY;
    logic [1:0]  OWNER;
    logic        LED;

    int checks   = 0;
    int failures = 0;

    blink_arbiter #(.TICK_DIV(TD), .GAP_HALVES(GH)) dut (
        .CLK50(CLK50), .RST(RST), .REQ(REQ), .CNT(CNT),
        .ACK(ACK), .DONE(DONE), .BUSY(BUSY), .OWNER(OWNER), .LED(LED)
    );

    always #5 CLK50 = ~CLK50;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] cnt;
        logic [3:0]  exp_ack;
        int          exp_owner;
        int          exp_n;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at the ACK cycle (k=0). Follows the sequence until DONE,
    // checking LED shape, pulse count, BUSY and DONE timing.
    task automatic run_seq(input string name, input int owner, input int n, input int drop_at);
        int done_at = -1;
        logic [3:0] done_val = 4'b0000;
        int led_err = 0;
        int busy_err = 0;
        int extra_ack = 0;
        int pulses = 1;
        logic prev_led = 1'b1;
        logic exp_led;
        logic busy_at_done = 1'b1;
        for (int k = 1; k <= (2*n + GH)*TD + 8 && done_at < 0; k++) begin
            if (k == drop_at) begin
                REQ = 4'b0000;
                CNT = ~CNT;
            end
            tick();
            exp_led = (k < 2*n*TD) && (((k / TD) % 2) == 0);
            if (LED !== exp_led) led_err++;
            if (LED && !prev_led) pulses++;
            prev_led = LED;
            if (ACK !== 4'b0000) extra_ack++;
            if (DONE !== 4'b0000) begin
                done_at      = k;
                done_val     = DONE;
                busy_at_done = BUSY;
            end else if (BUSY !== 1'b1) begin
                busy_err++;
            end
        end
        chk({name, "_led_shape_errs"}, led_err, 0);
        chk({name, "_pulses"}, pulses, n);
        chk({name, "_done_cycle"}, done_at, (2*n + GH)*TD);
        chk({name, "_done_onehot"}, done_val, 4'b0001 << owner);
        chk({name, "_busy_at_done"}, busy_at_done, 1'b0);
        chk({name, "_busy_gaps"}, busy_err, 0);
        chk({name, "_ack_in_seq"}, extra_ack, 0);
        chk({name, "_owner"}, OWNER, owner);
    endtask

    task automatic grant_check(input string name, input logic [3:0] exp_ack, input int exp_owner);
        chk({name, "_ack"}, ACK, exp_ack);
        chk({name, "_owner_at_ack"}, OWNER, exp_owner);
        chk({name, "_led_at_ack"}, LED, 1'b1);
        chk({name, "_busy_at_ack"}, BUSY, 1'b1);
    endtask

    initial begin
        int errs;

        vecs[0] = '{4'b0001, 16'h0002, 4'b0001, 0, 2};
        vecs[1] = '{4'b0010, 16'h0000, 4'b0010, 1, 16};
        vecs[2] = '{4'b1010, 16'h1050, 4'b1000, 3, 1};
        vecs[3] = '{4'b0110, 16'h0730, 4'b0010, 1, 3};
        vecs[4] = '{4'b0101, 16'h0204, 4'b0100, 2, 2};
        vecs[5] = '{4'b1111, 16'hF321, 4'b1000, 3, 15};

        #2 RST = 1'b1;
        #1;
        chk("reset_led", LED, 1'b0);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_owner", OWNER, 2'd0);
        chk("reset_ack", ACK, 4'b0000);
        chk("reset_done", DONE, 4'b0000);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("idle_busy", BUSY, 1'b0);

        for (int v = 0; v < 6; v++) begin
            REQ = vecs[v].req;
            CNT = vecs[v].cnt;
            tick();
            grant_check($sformatf("vec%0d", v), vecs[v].exp_ack, vecs[v].exp_owner);
            run_seq($sformatf("vec%0d", v), vecs[v].exp_owner, vecs[v].exp_n, 1);
        end

        // Round robin with all requests held: pointer is 3 after vec5.
        REQ = 4'b1111;
        CNT = 16'h1111;
        tick();
        grant_check("rr0", 4'b0001, 0);
        for (int g = 1; g <= 4; g++) begin
            run_seq($sformatf("rr%0d_seq", g - 1), (g - 1) % 4, 1, 1000);
            tick();
            grant_check($sformatf("rr%0d", g), 4'b0001 << (g % 4), g % 4);
        end
        run_seq("rr_last", 0, 1, 1);

        // Drop REQ and change CNT mid-sequence: pointer 0, so req 2 wins.
        REQ = 4'b0100;
        CNT = 16'h0300;
        tick();
        grant_check("drop", 4'b0100, 2);
        run_seq("drop", 2, 3, 5);

        // Reset mid-ON: req 3 granted from pointer 2.
        REQ = 4'b1000;
        CNT = 16'h5000;
        tick();
        grant_check("pre_rst", 4'b1000, 3);
        REQ = 4'b0000;
        tick();
        tick();
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_led", LED, 1'b0);
        chk("rst_mid_busy", BUSY, 1'b0);
        chk("rst_mid_owner", OWNER, 2'd0);
        tick();
        tick();
        RST = 1'b0;
        errs = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (DONE !== 4'b0000 || BUSY !== 1'b0 || LED !== 1'b0) errs++;
        end
        chk("post_rst_quiet", errs, 0);
        REQ = 4'b1001;
        CNT = 16'h2002;
        tick();
        grant_check("post_rst", 4'b0001, 0);
        run_seq("post_rst", 0, 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
